// File: rtl/npu_pkg.sv
// Shared NPU definitions: scratchpad geometry and the read-streamer FSM states.
package npu_pkg;

  localparam int unsigned SCRATCH_DATA_WIDTH = 32;
  localparam int unsigned SCRATCH_ENTRIES    = 1024;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } rd_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous fall-through FIFO on registered storage, with an occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full, do_push, do_pop;

  always_comb begin
    full    = (count_q == CntW'(DEPTH));
    do_pop  = pop_i && (count_q != '0);
    // A push into a full FIFO is fine when a pop frees the slot in the same cycle.
    do_push = push_i && (!full || do_pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      wptr_d = (wptr_q == PtrW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = (rptr_q == PtrW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
      end
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  push_when_full_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full && !pop_i))
    else $error("sync_fifo: push into full FIFO");

endmodule

// File: rtl/sram_rd_streamer.sv
// Streams len sequential SRAM words from base as a valid/ready stream with full backpressure.
module sram_rd_streamer
  import npu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SCRATCH_DATA_WIDTH,
  parameter int unsigned N_ENTRIES  = SCRATCH_ENTRIES,
  parameter int unsigned ADDRW      = $clog2(N_ENTRIES),
  parameter int unsigned LENW       = ADDRW + 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDRW-1:0]      base_addr_i,
  input  logic [LENW-1:0]       len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  sram_en_o,
  output logic                  sram_we_o,
  output logic [ADDRW-1:0]      sram_addr_o,
  input  logic [DATA_WIDTH-1:0] sram_data_i,
  input  logic                  sram_ready_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  rd_state_e           state_q, state_d;
  logic [ADDRW-1:0]    addr_q, addr_d;
  logic [LENW-1:0]     len_q, len_d;
  logic [LENW-1:0]     issued_q, issued_d;
  logic [LENW-1:0]     push_idx_q, push_idx_d;
  logic                inflight_q, inflight_d;
  logic                rd_en, credit_ok, push, pop, push_last, fifo_empty;
  logic [CntW-1:0]     fifo_count;
  logic [CntW:0]       occupancy;
  logic [DATA_WIDTH:0] fifo_rdata;

  always_comb begin
    occupancy = {1'b0, fifo_count} + {{CntW{1'b0}}, inflight_q};
    credit_ok = occupancy < (CntW + 1)'(FIFO_DEPTH);
    // Only accept SRAM data for reads this engine issued; drops anything left over from reset.
    push      = sram_ready_i && inflight_q;
    push_last = (push_idx_q == len_q - 1'b1);
    pop       = m_valid_o && m_ready_i;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    issued_d   = issued_q;
    push_idx_d = push_idx_q;
    rd_en      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (len_i == '0) begin
            state_d = StDone;
          end else begin
            addr_d     = base_addr_i;
            len_d      = len_i;
            issued_d   = '0;
            push_idx_d = '0;
            state_d    = StRun;
          end
        end
      end
      StRun: begin
        if ((issued_q < len_q) && credit_ok) begin
          rd_en    = 1'b1;
          issued_d = issued_q + 1'b1;
          addr_d   = (addr_q == ADDRW'(N_ENTRIES - 1)) ? '0 : addr_q + 1'b1;
          if (issued_d == len_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (pop && m_last_o) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (push) begin
      push_idx_d = push_idx_q + 1'b1;
    end
    inflight_d = rd_en;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      push_idx_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      push_idx_q <= push_idx_d;
      inflight_q <= inflight_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i ({push_last, sram_data_i}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign busy_o      = (state_q == StRun) || (state_q == StDrain);
  assign done_o      = (state_q == StDone);
  assign sram_en_o   = rd_en;
  assign sram_we_o   = 1'b0;
  assign sram_addr_o = addr_q;
  assign m_valid_o   = !fifo_empty;
  assign m_last_o    = fifo_rdata[DATA_WIDTH];
  assign m_data_o    = fifo_rdata[DATA_WIDTH-1:0];

endmodule
